// File: rtl/fpu_pkg.sv
// fpu_pkg: shared op codes, sequencer state encoding and the quiet-NaN constant
package fpu_pkg;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_RESP} state_t;
endpackage

// File: rtl/fpu_op_decode.sv
// fpu_op_decode: maps an 8-bit op code to a core select and one-hot core mask
module fpu_op_decode
  import fpu_pkg::*;
(
  input  logic [7:0] op,
  output logic [1:0] sel,
  output logic [3:0] mask
);
  // codes 0..3 pick their own core, anything else falls back to subtract
  always_comb begin
    sel = op > 8'd3 ? OP_SUB : op[1:0];
    mask = 4'b0001 << sel;
  end
endmodule

// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: issues one FP op at a time to one of four stream cores; FPU_SEQ_TIMEOUT_EN adds a SEND+WAIT timeout
module fpu_op_sequencer
  import fpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [31:0]  cmd_a,
  input  logic [31:0]  cmd_b,
  input  logic [7:0]   cmd_op,
  output logic [31:0]  a_tdata,
  output logic [31:0]  b_tdata,
  output logic [3:0]   a_tvalid,
  output logic [3:0]   b_tvalid,
  input  logic [3:0]   a_tready,
  input  logic [3:0]   b_tready,
  input  logic [3:0]   res_tvalid,
  input  logic [127:0] res_tdata,
  output logic [3:0]   res_tready,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [31:0]  rsp_data,
  output logic [1:0]   rsp_op,
  output logic         rsp_err
);
  state_t state;
  logic [1:0] dec_sel;
  logic [3:0] dec_mask, mask;
  logic a_left, b_left, res_fire, to_hit;

  fpu_op_decode u_dec (.op(cmd_op), .sel(dec_sel), .mask(dec_mask));

  // rsp_op holds the latched select for the whole operation
  assign mask = 4'b0001 << rsp_op;
  // valids only ever carry the selected bit, so stray readys/valids on other cores fall out here
  assign a_left = |(a_tvalid & ~a_tready);
  assign b_left = |(b_tvalid & ~b_tready);
  assign res_fire = |(res_tready & res_tvalid);

`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt;
  // cycles spent in SEND and WAIT; held at zero while idle so each command starts fresh
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (state == S_IDLE) cnt <= '0;
    else if (state == S_SEND || state == S_WAIT) cnt <= cnt + 1'b1;
  assign to_hit = (state == S_SEND || state == S_WAIT) && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign to_hit = 1'b0;
`endif

  // control FSM; every output is a flop written here
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      cmd_ready <= 1'b0;
      a_tdata <= '0;
      b_tdata <= '0;
      a_tvalid <= '0;
      b_tvalid <= '0;
      res_tready <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_op <= '0;
      rsp_err <= 1'b0;
    end else
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            a_tdata <= cmd_a;
            b_tdata <= cmd_b;
            rsp_op <= dec_sel;
            rsp_err <= 1'b0;
            a_tvalid <= dec_mask;
            b_tvalid <= dec_mask;
            state <= S_SEND;
          end
        end
        S_SEND: begin
          a_tvalid <= a_left ? mask : 4'd0;
          b_tvalid <= b_left ? mask : 4'd0;
          if (to_hit) begin
            a_tvalid <= '0;
            b_tvalid <= '0;
            rsp_data <= QNAN;
            rsp_err <= 1'b1;
            rsp_valid <= 1'b1;
            state <= S_RESP;
          end else if (!a_left && !b_left) begin
            res_tready <= mask;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (res_fire) begin
            rsp_data <= res_tdata[{rsp_op, 5'd0} +: 32];
            res_tready <= '0;
            rsp_valid <= 1'b1;
            state <= S_RESP;
          end else if (to_hit) begin
            res_tready <= '0;
            rsp_data <= QNAN;
            rsp_err <= 1'b1;
            rsp_valid <= 1'b1;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb_fpu_op_sequencer: table, random and corner-case checks of the FP op sequencer
module tb_fpu_op_sequencer;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] cmd_a, cmd_b, a_tdata, b_tdata, rsp_data;
  logic [7:0] cmd_op;
  logic [3:0] a_tvalid, b_tvalid, a_tready, b_tready, res_tvalid, res_tready;
  logic [127:0] res_tdata;
  logic [1:0] rsp_op;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fpu_op_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .a_tdata(a_tdata), .b_tdata(b_tdata), .a_tvalid(a_tvalid), .b_tvalid(b_tvalid),
    .a_tready(a_tready), .b_tready(b_tready),
    .res_tvalid(res_tvalid), .res_tdata(res_tdata), .res_tready(res_tready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_err(rsp_err)
  );

  typedef struct {
    logic [31:0] a, b;
    logic [7:0] op;
    int da, db, lat, rr;
    logic [31:0] res;
    logic [1:0] sel;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // architectural op mapping: 0..3 select their own core, anything else is subtract
  function automatic logic [1:0] ref_sel(input logic [7:0] op);
    return op < 8'd4 ? op[1:0] : 2'd1;
  endfunction

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {15'd0, cmd_ready, a_tvalid, b_tvalid, res_tready, rsp_valid, rsp_op, rsp_err}, 32'd0);
    chk({nm, "_rsp_data"}, rsp_data, 32'd0);
    chk({nm, "_a_tdata"}, a_tdata, 32'd0);
    chk({nm, "_b_tdata"}, b_tdata, 32'd0);
  endtask

  // one full transaction: the bench plays the cores (ready after da/db valid cycles,
  // result after lat cycles of res_tready) and the consumer (ready after rr response cycles)
  task automatic do_op(input vec_t v, input string nm);
    logic [3:0] m;
    logic [127:0] rd;
    int cyc, na, nb, nr, nv, first, mx;
    logic hs, bmask, bdata, bovl, brsp, bcr, e0;
    logic [31:0] d0;
    logic [1:0] o0;
    m = 4'b0001 << v.sel;
    cyc = 0; na = 0; nb = 0; nr = 0; nv = 0; first = 0;
    hs = 0; bmask = 0; bdata = 0; bovl = 0; brsp = 0; bcr = 0;
    d0 = '0; o0 = '0; e0 = 1'b0;
    mx = v.da > v.db ? v.da : v.db;
    cmd_valid = 1'b1; cmd_a = v.a; cmd_b = v.b; cmd_op = v.op;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_a = $urandom; cmd_b = $urandom; cmd_op = 8'($urandom);
    while (!hs && cyc < 200) begin
      cyc++;
      if (cmd_ready) bcr = 1'b1;
      if (((a_tvalid | b_tvalid | res_tready) & ~m) != 4'd0) bmask = 1'b1;
      if (|a_tvalid) begin na++; if (a_tdata !== v.a) bdata = 1'b1; end
      if (|b_tvalid) begin nb++; if (b_tdata !== v.b) bdata = 1'b1; end
      if (|res_tready) begin nr++; if (|{a_tvalid, b_tvalid}) bovl = 1'b1; end
      if (rsp_valid) begin
        nv++;
        if (nv == 1) begin first = cyc; d0 = rsp_data; o0 = rsp_op; e0 = rsp_err; end
        else if ({rsp_data, rsp_op, rsp_err} !== {d0, o0, e0}) brsp = 1'b1;
      end
      a_tready = (4'($urandom) & ~m) | ((|a_tvalid && na > v.da) ? m : 4'd0);
      b_tready = (4'($urandom) & ~m) | ((|b_tvalid && nb > v.db) ? m : 4'd0);
      rd = {$urandom, $urandom, $urandom, $urandom};
      rd[32*v.sel +: 32] = v.res;
      res_tdata = rd;
      res_tvalid = (4'($urandom) & ~m) | ((|res_tready && nr > v.lat) ? m : 4'd0);
      rsp_ready = rsp_valid && nv > v.rr;
      hs = rsp_ready;
      @(negedge clk);
    end
    a_tready = '0; b_tready = '0; res_tvalid = '0; rsp_ready = 1'b0;
    chk({nm, "_handshake"}, {31'd0, hs}, 32'd1);
    chk({nm, "_a_valid_cycles"}, na, v.da + 1);
    chk({nm, "_b_valid_cycles"}, nb, v.db + 1);
    chk({nm, "_res_ready_cycles"}, nr, v.lat + 1);
    chk({nm, "_rsp_valid_cycles"}, nv, v.rr + 1);
    chk({nm, "_latency"}, first, mx + v.lat + 3);
    chk({nm, "_rsp_data"}, d0, v.res);
    chk({nm, "_rsp_op"}, {30'd0, o0}, {30'd0, v.sel});
    chk({nm, "_rsp_err"}, {31'd0, e0}, 32'd0);
    chk({nm, "_other_cores"}, {31'd0, bmask}, 32'd0);
    chk({nm, "_data_stable"}, {31'd0, bdata}, 32'd0);
    chk({nm, "_wait_after_send"}, {31'd0, bovl}, 32'd0);
    chk({nm, "_rsp_stable"}, {31'd0, brsp}, 32'd0);
    chk({nm, "_cmd_ready_busy"}, {31'd0, bcr}, 32'd0);
    chk({nm, "_post_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({nm, "_post_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    vec_t v;
    int first, seen;
    logic [31:0] d;
    logic e, busy;
    cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_op = 0;
    a_tready = 0; b_tready = 0; res_tvalid = 0; res_tdata = 0; rsp_ready = 0;
    tbl[0] = '{32'h3F80_0000, 32'h4000_0000, 8'd0, 0, 0, 11, 0, 32'h4040_0000, 2'd0};
    tbl[1] = '{32'h40A0_0000, 32'h3F80_0000, 8'd7, 0, 0, 2, 0, 32'h4080_0000, 2'd1};
    tbl[2] = '{32'h4040_0000, 32'h4000_0000, 8'd2, 1, 4, 3, 0, 32'h40C0_0000, 2'd2};
    tbl[3] = '{32'h4100_0000, 32'h4000_0000, 8'd3, 0, 0, 1, 5, 32'h4080_0000, 2'd3};
    tbl[4] = '{32'h4000_0000, 32'h3F80_0000, 8'd1, 4, 1, 0, 1, 32'h3F80_0000, 2'd1};
    tbl[5] = '{32'hC000_0000, 32'h4000_0000, 8'hFF, 2, 2, 0, 0, 32'hC080_0000, 2'd1};
    tbl[6] = '{32'h1234_5678, 32'h9ABC_DEF0, 8'd4, 0, 3, 5, 2, 32'hDEAD_BEEF, 2'd1};
    tbl[7] = '{32'h3F00_0000, 32'h3F00_0000, 8'd2, 0, 0, 0, 0, 32'h3E80_0000, 2'd2};

    repeat (2) @(negedge clk);
    chk_zero("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_release", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 8; i++) do_op(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 40; i++) begin
      v.a = $urandom; v.b = $urandom;
      v.op = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      v.da = $urandom_range(0, 4); v.db = $urandom_range(0, 4);
      v.lat = $urandom_range(0, 8); v.rr = $urandom_range(0, 3);
      v.res = $urandom; v.sel = ref_sel(v.op);
      do_op(v, $sformatf("rnd%0d", i));
    end

    // core never accepts operands
    cmd_valid = 1'b1; cmd_a = 32'h4040_0000; cmd_b = 32'h0; cmd_op = 8'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    first = 0; d = '0; e = 1'b0; busy = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (rsp_valid && first == 0) begin
        first = c; d = rsp_data; e = rsp_err; busy = |{a_tvalid, b_tvalid, res_tready};
      end
      @(negedge clk);
    end
`ifdef FPU_SEQ_TIMEOUT_EN
    chk("to_cycle", first, TO + 1);
    chk("to_err", {31'd0, e}, 32'd1);
    chk("to_data", d, 32'h7FC0_0000);
    chk("to_valids_off", {31'd0, busy}, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("to_post_idle", {30'd0, rsp_valid, cmd_ready}, 32'd1);
`else
    chk("no_to_rsp", first, 32'd0);
    chk("no_to_still_sending", {28'd0, a_tvalid}, 32'h8);
    chk("no_to_err", {31'd0, rsp_err}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif

    // reset pulsed while waiting on the multiplier result
    cmd_valid = 1'b1; cmd_a = 32'h4000_0000; cmd_b = 32'h4000_0000; cmd_op = 8'd2;
    @(negedge clk);
    cmd_valid = 1'b0; a_tready = 4'b0100; b_tready = 4'b0100;
    @(negedge clk);
    a_tready = '0; b_tready = '0;
    chk("mid_in_wait", {28'd0, res_tready}, 32'h4);
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_reset");
    res_tvalid = 4'hF; res_tdata = {4{32'h4080_0000}};
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    res_tvalid = '0;
    chk("mid_no_rsp", seen, 32'd0);
    chk("mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    v = '{32'h4000_0000, 32'h4000_0000, 8'd2, 0, 1, 2, 1, 32'h4080_0000, 2'd2};
    do_op(v, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fpu_op_sequencer.md
FPU_OP_SEQUENCER -- requirements
Module: fpu_op_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the maximum cycles allowed in SEND+WAIT before abort.
REQ-002 SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1, command present.
REQ-005 SHALL have port cmd_ready, output, 1, command accepted when high with cmd_valid.
REQ-006 SHALL have ports cmd_a and cmd_b, input, 32 each, IEEE-754 single operands.
REQ-007 SHALL have port cmd_op, input, 8, operation code: 0 add, 1 sub, 2 mul, 3 div, any other value sub.
REQ-008 SHALL have ports a_tdata and b_tdata, output, 32 each, operand data shared by all four cores.
REQ-009 SHALL have ports a_tvalid, b_tvalid, a_tready and b_tready, 4 each, one bit per core (bit index = mapped op); the valids are outputs and the readys are inputs.
REQ-010 SHALL have ports res_tvalid (input, 4), res_tdata (input, 128, core n at bits [32n+31:32n]) and res_tready (output, 4).
REQ-011 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_data (output, 32), rsp_op (output, 2, mapped op) and rsp_err (output, 1, timeout flag).

Function
REQ-012 SHALL implement states IDLE, SEND, WAIT and RESP, with one operation outstanding at most.
REQ-013 IDLE: SHALL drive cmd_ready=1; on cmd_valid, SHALL register cmd_a, cmd_b and the mapped op, then go to SEND the next cycle.
REQ-014 SEND: SHALL assert a_tvalid[sel] and b_tvalid[sel] and hold the data stable.
REQ-015 SEND: each valid SHALL drop independently in the cycle after its tready is sampled high.
REQ-016 SEND: the block SHALL go to WAIT once both operand channels have completed, including the case where both complete in the same cycle.
REQ-017 WAIT: SHALL drive res_tready[sel]=1; on res_tvalid[sel], SHALL capture the selected 32-bit slice and go to RESP.
REQ-018 RESP: SHALL hold rsp_valid=1 with stable rsp_data, rsp_op and rsp_err until rsp_ready, then return to IDLE.
REQ-019 cmd_ready SHALL be 0 outside IDLE, so the minimum command-to-response latency is 3 cycles plus the core latency.
REQ-020 Non-selected a_tvalid, b_tvalid and res_tready bits SHALL be 0 at all times, and res_tvalid on non-selected cores SHALL be ignored.
REQ-021 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-022 While rst_n is low, the block SHALL be in IDLE, all valids and readys 0 except cmd_ready, which SHALL be 0 during reset and 1 in the first cycle after release.
REQ-023 While rst_n is low, rsp_data, rsp_op, rsp_err, a_tdata, b_tdata and the timeout counter SHALL all be 0.
REQ-024 Reset asserted mid-operation SHALL abandon the operation, and no response SHALL be produced for it.

Configuration
REQ-025 With FPU_SEQ_TIMEOUT_EN defined, a counter SHALL clear on entering SEND and increment each cycle in SEND and WAIT.
REQ-026 With FPU_SEQ_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 without completion, the block SHALL go to RESP with rsp_err=1 and rsp_data=32'h7FC00000, deasserting all valids and readys.
REQ-027 Without FPU_SEQ_TIMEOUT_EN, no counter SHALL exist, rsp_err SHALL be constant 0, and the block SHALL wait indefinitely.

Structure
REQ-028 A shared package fpu_pkg SHALL hold the op-code constants (ADD=0, SUB=1, MUL=2, DIV=3), the state encoding, and the QNAN constant 32'h7FC00000.
REQ-029 A sub-module fpu_op_decode SHALL map the 8-bit cmd_op to the 2-bit select and a 4-bit one-hot core mask.

Verification
REQ-030 Add: A=3F800000 and B=40000000 with op 0, core returns 40400000 after 11 cycles -> only core-0 valids toggle, and rsp_data=40400000, rsp_op=0, rsp_err=0.
REQ-031 Op 8'h7 with A=40A00000 and B=3F800000 -> only core 1 is driven (treated as sub), and rsp_op=1.
REQ-032 Skewed readys (a_tready at +1 cycle, b_tready at +4 cycles) -> a_tvalid drops first, b_tvalid holds with stable data, and WAIT is entered only after both.
REQ-033 Back-pressure with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data remain stable, and cmd_ready stays 0 until the handshake.
REQ-034 Timeout with macro defined and TIMEOUT_CYCLES=16, core never returns -> after 16 SEND+WAIT cycles, rsp_err=1 and rsp_data=7FC00000.
REQ-035 rst_n pulsed low during WAIT -> all outputs reset, no rsp_valid is produced, and a new command after reset completes normally.
